// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the iteration class selecting multiply or divide datapath.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

  typedef enum logic {
    CLS_MUL = 1'b0,
    CLS_DIV = 1'b1
  } mdu_class_e;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIVU) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_iter_step.sv
// Combinational single iteration: one shift-add multiply step or one
// restoring-divide step on a 2*WIDTH accumulator.
module mdu_iter_step
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               cls,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out,
  output logic               q_bit
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   sh_rem;
  logic [WIDTH+1:0] diff;
  logic             unused_diff_bit;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  // Divide:   acc = {partial remainder, remaining dividend bits}, shifted left,
  //           quotient bits enter at the bottom.
  assign mul_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} +
                   (acc_in[0] ? {1'b0, operand} : '0);
  assign sh_rem  = acc_in[2*WIDTH-1:WIDTH-1];
  assign diff    = {1'b0, sh_rem} - {2'b00, operand};
  assign unused_diff_bit = diff[WIDTH];

  always_comb begin
    acc_out = '0;
    q_bit   = 1'b0;
    if (mdu_class_e'(cls) == CLS_DIV) begin
      q_bit   = ~diff[WIDTH+1];
      acc_out = {(q_bit ? diff[WIDTH-1:0] : sh_rem[WIDTH-1:0]),
                 acc_in[WIDTH-2:0], q_bit};
    end else begin
      acc_out = {mul_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: operands are reduced to
// magnitudes at launch, iterated WIDTH times, then sign-corrected in FIX.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  input  logic             HI_WE,
  input  logic             LO_WE,
  input  logic [WIDTH-1:0] WD,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_in, op_q;
  logic [2*WIDTH-1:0] acc_q, step_acc;
  logic [WIDTH-1:0]   opnd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_lo_q, neg_hi_q, div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               in_signed, in_div, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot, rem, hi_res, lo_res;
  mdu_class_e         step_cls;
  logic               unused_qbit;

  assign op_in     = mdu_op_e'(OP);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign sign_a    = in_signed & SRC_A[WIDTH-1];
  assign sign_b    = in_signed & SRC_B[WIDTH-1];
  assign mag_a     = sign_a ? -SRC_A : SRC_A;
  assign mag_b     = sign_b ? -SRC_B : SRC_B;
  assign step_cls  = op_is_div(op_q) ? CLS_DIV : CLS_MUL;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .cls     (step_cls),
    .acc_in  (acc_q),
    .operand (opnd_q),
    .acc_out (step_acc),
    .q_bit   (unused_qbit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (START) state_d = S_CALC;
      S_CALC: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Divide by zero leaves the remainder equal to |A|, which the remainder
  // sign correction turns back into SRC_A; only LO needs forcing.
  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quot     = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    hi_res   = prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (op_is_div(op_q)) begin
      hi_res = neg_hi_q ? -rem : rem;
      lo_res = div_zero_q ? '1 : (neg_lo_q ? -quot : quot);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op_q       <= MDU_MULTU;
      acc_q      <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            op_q       <= op_in;
            cnt_q      <= '0;
            neg_lo_q   <= sign_a ^ sign_b;
            neg_hi_q   <= in_div ? sign_a : (sign_a ^ sign_b);
            div_zero_q <= in_div && (SRC_B == '0);
            if (in_div) begin
              acc_q  <= {{WIDTH{1'b0}}, mag_a};
              opnd_q <= mag_b;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, mag_b};
              opnd_q <= mag_a;
            end
          end else begin
            if (HI_WE) hi_q <= WD;
            if (LO_WE) lo_q <= WD;
          end
        end
        S_CALC: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q + 1'b1;
        end
        S_FIX: begin
          hi_q   <= hi_res;
          lo_q   <= lo_res;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state_q != S_IDLE);
  assign DONE = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: reference results are computed with
// native 64-bit arithmetic at launch and compared when DONE fires.
module tb_mul_div_unit;
  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         START = 1'b0;
  logic [1:0]   OP = 2'b00;
  logic [W-1:0] SRC_A = '0;
  logic [W-1:0] SRC_B = '0;
  logic         HI_WE = 1'b0;
  logic         LO_WE = 1'b0;
  logic [W-1:0] WD = '0;
  logic         BUSY, DONE;
  logic [W-1:0] HI, LO;

  always #5 CLK = ~CLK;

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP),
    .SRC_A(SRC_A), .SRC_B(SRC_B), .HI_WE(HI_WE), .LO_WE(LO_WE), .WD(WD),
    .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input string tag);
    exp_t e;
    logic [63:0] p;
    e.tag = tag;
    e.hi  = '0;
    e.lo  = '0;
    case (op)
      2'b00: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      2'b01: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      2'b10: begin
        if (b == 0) begin e.lo = '1; e.hi = a; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      default: begin
        if (b == 0) begin e.lo = '1; e.hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = '0;
        end else begin
          e.lo = $signed(a) / $signed(b);
          e.hi = $signed(a) % $signed(b);
        end
      end
    endcase
    return e;
  endfunction

  // Drives START for one cycle; returns at the falling edge after E0.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic push, input logic lo_we, input string tag);
    @(negedge CLK);
    START = 1'b1; OP = op; SRC_A = a; SRC_B = b;
    LO_WE = lo_we; WD = 32'h5555_5555;
    if (push) sb.push_back(model(op, a, b, tag));
    @(negedge CLK);
    START = 1'b0; LO_WE = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int restart_at, input int hiwe_at);
    int busy;
    exp_t e;
    busy = 0;
    while (BUSY && busy < 100) begin
      busy++;
      START = (busy == restart_at);
      HI_WE = (busy == hiwe_at);
      if (busy == restart_at) SRC_A = 32'd100;
      if (busy == hiwe_at) WD = 32'hDEAD;
      @(negedge CLK);
    end
    START = 1'b0; HI_WE = 1'b0;
    chk({tag, "_busy_cycles"}, busy, 33);
    chk({tag, "_done"}, DONE, 1);
    chk({tag, "_sb_size"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_hi"}, HI, e.hi);
      chk({e.tag, "_lo"}, LO, e.lo);
    end
    @(negedge CLK);
    chk({tag, "_done_pulse"}, DONE, 0);
    chk({tag, "_idle"}, BUSY, 0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    launch(op, a, b, 1'b1, 1'b0, tag);
    finish_op(tag, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    repeat (2) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    RST = 1'b1;

    @(negedge CLK);
    HI_WE = 1'b1; LO_WE = 1'b1; WD = 32'hA5A5_A5A5;
    @(negedge CLK);
    HI_WE = 1'b0; LO_WE = 1'b0;
    chk("mt_both_hi", HI, 32'hA5A5_A5A5);
    chk("mt_both_lo", LO, 32'hA5A5_A5A5);
    LO_WE = 1'b1; WD = 32'h77;
    @(negedge CLK);
    LO_WE = 1'b0;
    chk("mtlo_only_lo", LO, 32'h77);
    chk("mtlo_only_hi", HI, 32'hA5A5_A5A5);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5,         "mult_neg");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2,         "div_neg");
    run_op(2'b10, 32'h64,        32'd0,         "divu_zero");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0,         "div_zero_neg");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    run_op(2'b11, 32'd7,         32'hFFFF_FFFE, "div_negdiv");

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? '0 : $urandom;
      run_op(rop, ra, rb, "rand");
    end

    @(negedge CLK);
    HI_WE = 1'b1; WD = 32'h1234;
    @(negedge CLK);
    HI_WE = 1'b0;
    chk("mthi_1234", HI, 32'h1234);
    launch(2'b10, 32'd9, 32'd4, 1'b1, 1'b0, "divu_restart");
    finish_op("divu_restart", 5, 10);
    chk("no_second_start", BUSY, 0);

    launch(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, "abort");
    repeat (9) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_stays_idle", BUSY, 0);

    launch(2'b00, 32'd6, 32'd7, 1'b1, 1'b1, "multu_6x7");
    finish_op("multu_6x7", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
